program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Parametrised successor to the core's program counter.
- Adds selectable width, a hardware call/return stack of configurable depth, a stall hold, and sticky stack-error flags.
- Sits between the control unit and instruction memory. The control unit drives one-hot-ish command strobes, and PC_out addresses instruction ROM.

Parameters:
- PC_WIDTH, 8, width of program counter and of each stack entry.
- STACK_DEPTH, 4, number of return-address entries (>=1).
- RESET_VECTOR, 0, value loaded into PC_out on reset (PC_WIDTH bits).

Ports:
- CLK  input  1  system clock, rising-edge.
- RESET  input  1  asynchronous active-low reset.
- PC_in  input  PC_WIDTH  jump/call target address.
- PC_load  input  1  jump: PC_out <= PC_in.
- PC_inc  input  1  advance: PC_out <= PC_out + 1.
- PC_call  input  1  push PC_out+1, then PC_out <= PC_in.
- PC_ret  input  1  pop top of stack into PC_out.
- stall  input  1  hold all state this cycle.
- err_clear  input  1  clear sticky error flags.
- PC_out  output  PC_WIDTH  current program address (registered).
- sp_count  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  sp_count == STACK_DEPTH (combinational from sp_count).
- stack_empty  output  1  sp_count == 0 (combinational from sp_count).
- ovf_err  output  1  sticky: call attempted while full.
- unf_err  output  1  sticky: return attempted while empty.

Behaviour:
- Interface: one clock, CLK. RESET is asynchronous and active-low.
- Reset (RESET==0, asynchronous, any time including mid-call):
  - PC_out = RESET_VECTOR; sp_count = 0; ovf_err = unf_err = 0.
  - Consequently stack_empty = 1 and stack_full = 0.
  - Stack RAM contents are not reset and are don't-care.
- All updates occur on the rising CLK edge. PC_out reflects a command one cycle after it is sampled. There is no combinational path from inputs to PC_out.
- Command priority, highest first: stall > PC_ret > PC_call > PC_load > PC_inc > hold. Exactly one action is taken per cycle; lower-priority strobes asserted in the same cycle are ignored.
- stall=1:
  - PC_out, stack and sp_count hold.
  - Error flags hold. err_clear is also ignored while stalled.
- PC_ret, stack not empty: PC_out <= stack[sp_count-1]; sp_count decrements.
- PC_ret, stack empty: PC_out holds; sp_count stays 0; unf_err <= 1.
- PC_call, stack not full: stack[sp_count] <= PC_out+1 (mod 2^PC_WIDTH); PC_out <= PC_in; sp_count increments.
- PC_call, stack full: no push and no jump; PC_out holds; ovf_err <= 1.
- PC_load: PC_out <= PC_in; stack untouched.
- PC_inc: PC_out <= PC_out + 1. Wraps from 2^PC_WIDTH-1 to 0 with no flag.
- Return address of a call at PC_out = all-ones is 0 (wrap).
- Error flags:
  - Set only by the failing command.
  - Cleared by err_clear=1 when not stalled.
  - If err_clear and a new error event occur in the same cycle, the set wins (flag = 1).
- sp_count never exceeds STACK_DEPTH and never underflows below 0.
- STACK_DEPTH=1 must work: full and empty are mutually exclusive, and a single push/pop toggles between them.

Test Plan:
- Reset/increment: release RESET with RESET_VECTOR=0 and PC_inc=1 for 300 cycles (PC_WIDTH=8) -> PC_out counts 0..255, wraps to 0 at cycle 256, then continues 1..43. No flag changes.
- Call/return nesting: PC_out=0x10, PC_call with PC_in=0x40 -> PC_out=0x40, sp_count=1. Then PC_call PC_in=0x80 from 0x40 -> sp_count=2. PC_ret -> PC_out=0x41; PC_ret -> PC_out=0x11, stack_empty=1.
- Overflow (STACK_DEPTH=4): perform 4 calls -> stack_full=1. A 5th call with PC_in=0xAA -> PC_out unchanged, sp_count=4, ovf_err=1. Then 4 returns restore addresses in LIFO order.
- Underflow and sticky clear: PC_ret on empty stack -> PC_out holds, unf_err=1. Flag remains 1 over 10 idle cycles. Assert err_clear -> 0. err_clear together with a failing PC_ret -> unf_err stays 1.
- Priority and stall:
  - PC_ret+PC_call+PC_load+PC_inc together with sp_count=1 -> only the pop occurs.
  - stall=1 with all strobes for 5 cycles -> PC_out, sp_count and flags unchanged.
- Asynchronous reset mid-operation: assert RESET low between clock edges with sp_count=3, PC_out=0x57, ovf_err=1 -> PC_out=RESET_VECTOR, sp_count=0 and flags=0 immediately, without waiting for a clock edge. After release, PC_ret sets unf_err.

Source files
------------

// File: rtl/program_sequencer.sv
// ---------------------------------------------------------------------------
// program_sequencer
//
// Program counter with a hardware call/return stack, a stall hold and
// sticky stack-error flags. It sits between the control unit and the
// instruction ROM. The control unit drives the command strobes, and PC_out
// addresses the ROM.
//
// One command is taken per cycle, highest priority first:
//     stall > PC_ret > PC_call > PC_load > PC_inc > hold
//
// Parameters
//   PC_WIDTH      width of the program counter and of each stack entry
//   STACK_DEPTH   number of return-address entries (>= 1)
//   RESET_VECTOR  PC_out value after reset
//
// Ports
//   CLK          rising-edge clock
//   RESET        asynchronous active-low reset
//   PC_in        jump/call target address
//   PC_load      jump to PC_in
//   PC_inc       advance PC_out by one (wraps silently)
//   PC_call      push PC_out+1, then jump to PC_in
//   PC_ret       pop the top of stack into PC_out
//   stall        hold all state, including the error flags
//   err_clear    clear the sticky error flags (ignored while stalled)
//   PC_out       current program address (registered)
//   sp_count     number of valid stack entries
//   stack_full   sp_count == STACK_DEPTH
//   stack_empty  sp_count == 0
//   ovf_err      sticky: a call was attempted while the stack was full
//   unf_err      sticky: a return was attempted while the stack was empty
// ---------------------------------------------------------------------------
module program_sequencer #(
    parameter int                  PC_WIDTH     = 8,
    parameter int                  STACK_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [PC_WIDTH-1:0]                PC_in,
    input  logic                               PC_load,
    input  logic                               PC_inc,
    input  logic                               PC_call,
    input  logic                               PC_ret,
    input  logic                               stall,
    input  logic                               err_clear,
    output logic [PC_WIDTH-1:0]                PC_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_count,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               ovf_err,
    output logic                               unf_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    // A one-entry stack still needs a one-bit index.
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [SP_W-1:0]     sp_count_q, sp_count_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    // Return-address storage. It has no reset because only entries below
    // sp_count are ever read.
    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic                push;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    top_idx;
    logic                full;
    logic                empty;

    assign pc_plus1 = pc_q + PC_WIDTH'(1);
    assign full     = (sp_count_q == SP_W'(STACK_DEPTH));
    assign empty    = (sp_count_q == '0);
    // Both indices are used only when they are in range: a push happens
    // only when the stack is not full, and a pop only when it is not empty.
    assign push_idx = IDX_W'(sp_count_q);
    assign top_idx  = IDX_W'(sp_count_q - SP_W'(1));

    // Next-state logic. The if/else chain encodes the command priority. The
    // error clear is applied before the error checks, so a new error in the
    // same cycle overrides the clear.
    always_comb begin
        pc_d       = pc_q;
        sp_count_d = sp_count_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        push       = 1'b0;

        if (!stall) begin
            if (err_clear) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end

            if (PC_ret) begin
                if (!empty) begin
                    pc_d       = stack_mem[top_idx];
                    sp_count_d = sp_count_q - SP_W'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end else if (PC_call) begin
                if (!full) begin
                    push       = 1'b1;
                    pc_d       = PC_in;
                    sp_count_d = sp_count_q + SP_W'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (PC_load) begin
                pc_d = PC_in;
            end else if (PC_inc) begin
                pc_d = pc_plus1;
            end
        end
    end

    // State register. The asynchronous reset takes effect even in the
    // middle of a call sequence.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q       <= RESET_VECTOR;
            sp_count_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            sp_count_q <= sp_count_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Stack write port. The return address wraps to 0 when PC_out is all ones.
    always_ff @(posedge CLK) begin
        if (push) begin
            stack_mem[push_idx] <= pc_plus1;
        end
    end

    assign PC_out      = pc_q;
    assign sp_count    = sp_count_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// ---------------------------------------------------------------------------
// tb_program_sequencer
//
// Self-checking bench for program_sequencer. The main instance uses the
// default parameters (8-bit PC, 4-deep stack, reset vector 0). A second
// instance uses a 1-deep stack and reset vector 0x20.
//
// The reference model keeps the stack as a queue and computes the PC with
// plain modulo-256 arithmetic. Inputs are driven on the falling edge, and
// outputs are checked on the following falling edge.
// ---------------------------------------------------------------------------
module tb_program_sequencer;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] PC_in;
    logic       PC_load, PC_inc, PC_call, PC_ret, stall, err_clear;
    logic [7:0] PC_out;
    logic [2:0] sp_count;
    logic       stack_full, stack_empty, ovf_err, unf_err;

    // Second instance: 1-deep stack, reset vector 0x20.
    logic [7:0] d1_in;
    logic       d1_call, d1_ret;
    logic       d1_zero = 1'b0;
    logic [7:0] d1_pc;
    logic [0:0] d1_sp;
    logic       d1_full, d1_empty, d1_ovf, d1_unf;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_pc;
    int m_stack[$];
    bit m_ovf, m_unf;

    typedef struct {
        bit         st, rt, cl, ld, ic, cr;
        logic [7:0] din;
        logic [7:0] exp_pc;
        logic [2:0] exp_sp;
        bit         exp_ovf, exp_unf;
    } vec_t;

    vec_t vecs[$];

    always #5 CLK = ~CLK;

    program_sequencer #(.PC_WIDTH(8), .STACK_DEPTH(DEPTH), .RESET_VECTOR(8'h00)) dut (
        .CLK(CLK), .RESET(RESET), .PC_in(PC_in), .PC_load(PC_load), .PC_inc(PC_inc),
        .PC_call(PC_call), .PC_ret(PC_ret), .stall(stall), .err_clear(err_clear),
        .PC_out(PC_out), .sp_count(sp_count), .stack_full(stack_full),
        .stack_empty(stack_empty), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    program_sequencer #(.PC_WIDTH(8), .STACK_DEPTH(1), .RESET_VECTOR(8'h20)) dut_d1 (
        .CLK(CLK), .RESET(RESET), .PC_in(d1_in), .PC_load(d1_zero), .PC_inc(d1_zero),
        .PC_call(d1_call), .PC_ret(d1_ret), .stall(d1_zero), .err_clear(d1_zero),
        .PC_out(d1_pc), .sp_count(d1_sp), .stack_full(d1_full),
        .stack_empty(d1_empty), .ovf_err(d1_ovf), .unf_err(d1_unf)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_pc = 0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic modelStep(input bit st, rt, cl, ld, ic, cr, input logic [7:0] din);
        if (st) return;
        if (cr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (rt) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else m_unf = 1'b1;
        end else if (cl) begin
            if (m_stack.size() < DEPTH) begin
                m_stack.push_back((m_pc + 1) % 256);
                m_pc = int'(din);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (ld) begin
            m_pc = int'(din);
        end else if (ic) begin
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    // Drive one command on the falling edge, let the rising edge take it,
    // advance the model, and return on the next falling edge.
    task automatic applyStimulus(input bit st, rt, cl, ld, ic, cr, input logic [7:0] din);
        stall     = st;
        PC_ret    = rt;
        PC_call   = cl;
        PC_load   = ld;
        PC_inc    = ic;
        err_clear = cr;
        PC_in     = din;
        @(posedge CLK);
        modelStep(st, rt, cl, ld, ic, cr, din);
        @(negedge CLK);
    endtask

    // Compare every output against the reference model.
    task automatic checkOutput(input string tag);
        checkVal({tag, " pc"},    32'(PC_out),      32'(m_pc));
        checkVal({tag, " sp"},    32'(sp_count),    32'(m_stack.size()));
        checkVal({tag, " full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
        checkVal({tag, " empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
        checkVal({tag, " ovf"},   32'(ovf_err),     32'(m_ovf));
        checkVal({tag, " unf"},   32'(unf_err),     32'(m_unf));
    endtask

    // Compare every output against hand-written constants.
    task automatic checkState(input string tag, input logic [7:0] pc, input int sp, input bit ovf, input bit unf);
        checkVal({tag, " pc"},    32'(PC_out),      32'(pc));
        checkVal({tag, " sp"},    32'(sp_count),    32'(sp));
        checkVal({tag, " full"},  32'(stack_full),  32'(sp == DEPTH));
        checkVal({tag, " empty"}, 32'(stack_empty), 32'(sp == 0));
        checkVal({tag, " ovf"},   32'(ovf_err),     32'(ovf));
        checkVal({tag, " unf"},   32'(unf_err),     32'(unf));
    endtask

    // Drive one call/return command into the 1-deep instance.
    task automatic d1Step(input bit rt, cl, input logic [7:0] din);
        d1_ret  = rt;
        d1_call = cl;
        d1_in   = din;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic d1Check(input string tag, input logic [7:0] pc, input bit sp, input bit ovf, input bit unf);
        checkVal({tag, " pc"},    32'(d1_pc),    32'(pc));
        checkVal({tag, " sp"},    32'(d1_sp),    32'(sp));
        checkVal({tag, " full"},  32'(d1_full),  32'(sp));
        checkVal({tag, " empty"}, 32'(d1_empty), 32'(!sp));
        checkVal({tag, " ovf"},   32'(d1_ovf),   32'(ovf));
        checkVal({tag, " unf"},   32'(d1_unf),   32'(unf));
    endtask

    initial begin
        RESET = 1'b0;
        stall = 1'b0; PC_ret = 1'b0; PC_call = 1'b0; PC_load = 1'b0;
        PC_inc = 1'b0; err_clear = 1'b0; PC_in = 8'h00;
        d1_ret = 1'b0; d1_call = 1'b0; d1_in = 8'h00;
        modelReset();

        // Reset state of both instances.
        repeat (2) @(negedge CLK);
        checkState("reset", 8'h00, 0, 1'b0, 1'b0);
        d1Check("d1 reset", 8'h20, 1'b0, 1'b0, 1'b0);
        RESET = 1'b1;

        // 1-deep stack: a single push fills it, and a single pop empties it.
        d1Step(1'b0, 1'b1, 8'h40); d1Check("d1 call",     8'h40, 1'b1, 1'b0, 1'b0);
        d1Step(1'b0, 1'b1, 8'h50); d1Check("d1 ovf",      8'h40, 1'b1, 1'b1, 1'b0);
        d1Step(1'b1, 1'b0, 8'h00); d1Check("d1 ret",      8'h21, 1'b0, 1'b1, 1'b0);
        d1Step(1'b1, 1'b0, 8'h00); d1Check("d1 unf",      8'h21, 1'b0, 1'b1, 1'b1);
        d1Step(1'b0, 1'b0, 8'h00);

        // Increment run through the 8-bit wrap.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput("inc");
            if (i == 255) checkVal("inc wrap", 32'(PC_out), 32'h0);
        end
        checkState("inc end", 8'd44, 0, 1'b0, 1'b0);

        // Table: nesting, underflow and clear, priority, stall.
        // fields: st rt cl ld ic cr din | pc sp ovf unf
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h10, 8'h10,3'd0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h40, 8'h40,3'd1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h80, 8'h80,3'd2,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h41,3'd1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h11,3'd0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h11,3'd0,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h11,3'd0,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h11,3'd0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h11,3'd0,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h11,3'd0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h30, 8'h30,3'd1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,8'h99, 8'h12,3'd0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h50, 8'h50,3'd1,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,8'h77, 8'h50,3'd1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,8'h22, 8'h22,3'd1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,8'h60, 8'h60,3'd2,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h61,3'd2,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h23,3'd1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h13,3'd0,1'b0,1'b0});
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].st, vecs[i].rt, vecs[i].cl, vecs[i].ld, vecs[i].ic, vecs[i].cr, vecs[i].din);
            checkState($sformatf("vec%0d", i), vecs[i].exp_pc, int'(vecs[i].exp_sp), vecs[i].exp_ovf, vecs[i].exp_unf);
        end

        // Overflow: fill the stack, reject a fifth call, stall, then unwind in LIFO order.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hD0);
        checkState("full", 8'hD0, 4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        checkState("ovf call", 8'hD0, 4, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
            checkState("stall", 8'hD0, 4, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); checkState("pop1", 8'hC1, 3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); checkState("pop2", 8'hB1, 2, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); checkState("pop3", 8'hA1, 1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); checkState("pop4", 8'h14, 0, 1'b1, 1'b0);

        // A call from address 0xFF pushes the wrapped return address 0.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05); checkState("wrap call", 8'h05, 1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); checkState("wrap ret",  8'h00, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00); checkState("ovf clear", 8'h00, 0, 1'b0, 1'b0);

        // Asynchronous reset between clock edges with sp=3, pc=0x57 and ovf set.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); checkState("pre-rst pop", 8'h34, 3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h57); checkState("pre-rst",     8'h57, 3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #2 RESET = 1'b0;
        #1 checkState("async rst", 8'h00, 0, 1'b0, 1'b0);
        modelReset();
        @(negedge CLK);
        RESET = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkState("post-rst unf", 8'h00, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            checkState("unf sticky", 8'h00, 0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checkState("unf clear", 8'h00, 0, 1'b0, 1'b0);

        // Randomized commands checked against the reference model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 1) == 0, $urandom_range(0, 9) == 0,
                          8'($urandom_range(0, 255)));
            checkOutput("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
